// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared definitions for the branch resolution unit:
//                condition codes, 2-bit predictor counter encodings and a
//                width-generic branch condition evaluator.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Branch condition codes
    localparam logic [2:0] COND_EQ     = 3'b000;
    localparam logic [2:0] COND_NE     = 3'b001;
    localparam logic [2:0] COND_NEVER  = 3'b010;
    localparam logic [2:0] COND_ALWAYS = 3'b011;
    localparam logic [2:0] COND_LT     = 3'b100;
    localparam logic [2:0] COND_GE     = 3'b101;
    localparam logic [2:0] COND_LTU    = 3'b110;
    localparam logic [2:0] COND_GEU    = 3'b111;

    // 2-bit saturating direction counter states
    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Widest operand the evaluator handles; callers zero-extend into it
    localparam int unsigned MAX_XLEN = 64;
    typedef logic [MAX_XLEN-1:0] wide_t;

    // Never/always carry no data-dependent direction
    function automatic logic is_conditional(input logic [2:0] cond);
        return (cond != COND_NEVER) && (cond != COND_ALWAYS);
    endfunction

    // Evaluate a branch condition on zero-extended operands of 'width' bits.
    // Signed ordering is obtained by flipping the operand sign bit, which maps
    // two's-complement order onto unsigned order.
    function automatic logic eval_cond(input wide_t a, input wide_t b,
                                       input logic [2:0] cond,
                                       input int unsigned width);
        wide_t c_sign_mask;
        logic  w_eq;
        logic  w_ult;
        logic  w_slt;
        logic  w_res;
        c_sign_mask = wide_t'(1) << (width - 1);
        w_eq  = (a == b);
        w_ult = (a < b);
        w_slt = ((a ^ c_sign_mask) < (b ^ c_sign_mask));
        case (cond)
            COND_EQ:     w_res = w_eq;
            COND_NE:     w_res = !w_eq;
            COND_NEVER:  w_res = 1'b0;
            COND_ALWAYS: w_res = 1'b1;
            COND_LT:     w_res = w_slt;
            COND_GE:     w_res = !w_slt;
            COND_LTU:    w_res = w_ult;
            default:     w_res = !w_ult;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_bht.sv
`default_nettype none
// ============================================================================
//  Module      : branch_bht
//  Description : Direct-mapped table of 2-bit saturating direction counters
//                with a combinational read port and a synchronous update port.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_bht
    import branch_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    ctr_t r_cnt [ENTRIES];
    ctr_t w_cur;
    ctr_t w_next;

    // Read returns the pre-update value on a same-cycle index collision
    assign rd_taken = r_cnt[rd_idx][1];
    assign w_cur    = r_cnt[upd_idx];

    // Saturating step of the counter being trained
    always_comb begin
        w_next = w_cur;
        if (upd_taken) begin
            if (w_cur != CTR_ST) w_next = w_cur + 2'd1;
        end else begin
            if (w_cur != CTR_SNT) w_next = w_cur - 2'd1;
        end
    end

    // Counter array: reset to weakly not-taken, single-entry update per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) r_cnt[i] <= CTR_WNT;
        end else if (upd_en) begin
            r_cnt[upd_idx] <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_unit
//  Description : Branch resolution with a registered, handshaked result
//                stage, a trainable direction predictor and performance
//                counters for resolved branches and mispredictions.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] res_a,
    input  logic [XLEN-1:0] res_b,
    input  logic [XLEN-1:0] res_target,
    input  logic [2:0]      res_cond,
    input  logic            res_pred_taken,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic [XLEN-1:0] out_next_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic             r_valid;
    logic             r_taken;
    logic             r_mispredict;
    logic [XLEN-1:0]  r_next_pc;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_mp_count;

    logic             w_accept;
    logic             w_taken;
    logic             w_mispredict;
    logic             w_conditional;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_unused;

    // Only the word-index bits of the fetch PC select a predictor entry
    assign w_unused = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

    assign res_ready     = !r_valid || out_ready;
    assign w_accept      = res_valid && res_ready;
    assign w_taken       = eval_cond(wide_t'(res_a), wide_t'(res_b), res_cond, XLEN);
    assign w_mispredict  = (w_taken != res_pred_taken);
    assign w_conditional = is_conditional(res_cond);
    assign w_next_pc     = w_taken ? res_target : (res_pc + XLEN'(4));

    branch_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (pred_pc[IDX_W+1:2]),
        .rd_taken  (pred_taken),
        .upd_en    (w_accept && w_conditional),
        .upd_idx   (res_pc[IDX_W+1:2]),
        .upd_taken (w_taken)
    );

    // Result stage: flush wins over a same-cycle accept, data only moves on accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_next_pc    <= '0;
        end else begin
            if (flush)         r_valid <= 1'b0;
            else if (w_accept) r_valid <= 1'b1;
            else if (out_ready) r_valid <= 1'b0;
            if (w_accept) begin
                r_taken      <= w_taken;
                r_mispredict <= w_mispredict;
                r_next_pc    <= w_next_pc;
            end
        end
    end

    // Saturating counts of conditional branches and their mispredictions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_count <= '0;
            r_mp_count <= '0;
        end else if (w_accept && w_conditional) begin
            if (r_br_count != '1) r_br_count <= r_br_count + CNT_W'(1);
            if (w_mispredict && (r_mp_count != '1)) r_mp_count <= r_mp_count + CNT_W'(1);
        end
    end

    assign out_valid      = r_valid;
    assign out_taken      = r_taken;
    assign out_mispredict = r_mispredict;
    assign out_next_pc    = r_next_pc;
    assign br_count       = r_br_count;
    assign mp_count       = r_mp_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_unit
//  Description : Self-checking bench for branch_unit, comparing two instances
//                (wide and 2-bit performance counters) against a behavioural
//                model of the resolve, predictor and counter rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        res_valid;
    logic [31:0] res_pc, res_a, res_b, res_target;
    logic [2:0]  res_cond;
    logic        res_pred_taken;
    logic        flush;
    logic        out_ready;

    logic        pred_taken, res_ready, out_valid, out_taken, out_mispredict;
    logic [31:0] out_next_pc;
    logic [15:0] br_count, mp_count;

    logic        s_pred_taken, s_res_ready, s_out_valid, s_out_taken, s_out_mispredict;
    logic [31:0] s_out_next_pc;
    logic [1:0]  s_br_count, s_mp_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_bht [16];
    bit          m_valid, m_taken, m_mp;
    logic [31:0] m_npc;
    int          m_br, m_mpc;

    always #5 clk = ~clk;

    branch_unit #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_a(res_a), .res_b(res_b), .res_target(res_target),
        .res_cond(res_cond), .res_pred_taken(res_pred_taken), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_mispredict(out_mispredict), .out_next_pc(out_next_pc),
        .br_count(br_count), .mp_count(mp_count)
    );

    branch_unit #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(s_pred_taken),
        .res_valid(res_valid), .res_ready(s_res_ready), .res_pc(res_pc),
        .res_a(res_a), .res_b(res_b), .res_target(res_target),
        .res_cond(res_cond), .res_pred_taken(res_pred_taken), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_taken(s_out_taken),
        .out_mispredict(s_out_mispredict), .out_next_pc(s_out_next_pc),
        .br_count(s_br_count), .mp_count(s_mp_count)
    );

    function automatic bit ref_taken(logic [31:0] a, logic [31:0] b, logic [2:0] c);
        case (c)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return 1'b0;
            3'd3:    return 1'b1;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_valid = 0; m_taken = 0; m_mp = 0; m_npc = '0;
        m_br = 0; m_mpc = 0;
    endtask

    // One clock of stimulus: drive, check combinational outputs, advance the
    // model across the edge, then check every registered output.
    task automatic step(input bit v, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit pred, input bit ordy,
                        input bit fl, input logic [31:0] ppc);
        bit exp_ready, acc, tk;
        int idx;
        res_valid = v; res_cond = c; res_a = a; res_b = b; res_pc = pc;
        res_target = tgt; res_pred_taken = pred; out_ready = ordy; flush = fl;
        pred_pc = ppc;
        #1;
        exp_ready = !m_valid || ordy;
        check("res_ready", 64'(res_ready), 64'(exp_ready));
        check("pred_taken", 64'(pred_taken), 64'(m_bht[ppc[5:2]] >= 2));
        check("sat_pred_taken", 64'(s_pred_taken), 64'(m_bht[ppc[5:2]] >= 2));
        @(posedge clk);
        if (!rst_n) begin
            reset_model();
        end else begin
            acc = v && exp_ready;
            if (acc) begin
                tk  = ref_taken(a, b, c);
                idx = int'(pc[5:2]);
                if (c != 3'd2 && c != 3'd3) begin
                    if (tk) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
                    else    m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
                    m_br++;
                    if (tk != pred) m_mpc++;
                end
                m_taken = tk;
                m_mp    = (tk != pred);
                m_npc   = tk ? tgt : pc + 32'd4;
            end
            if (fl)        m_valid = 0;
            else if (acc)  m_valid = 1;
            else if (ordy) m_valid = 0;
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_taken", 64'(out_taken), 64'(m_taken));
        check("out_mispredict", 64'(out_mispredict), 64'(m_mp));
        check("out_next_pc", 64'(out_next_pc), 64'(m_npc));
        check("br_count", 64'(br_count), 64'(sat(m_br, 65535)));
        check("mp_count", 64'(mp_count), 64'(sat(m_mpc, 65535)));
        check("sat_br_count", 64'(s_br_count), 64'(sat(m_br, 3)));
        check("sat_mp_count", 64'(s_mp_count), 64'(sat(m_mpc, 3)));
    endtask

    initial begin : main
        logic [7:0]  sweep_exp;
        logic [31:0] ra, rb, rpc;
        logic [2:0]  rc;

        reset_model();
        rst_n = 1'b0;
        res_valid = 0; res_cond = 0; res_a = 0; res_b = 0; res_pc = 0;
        res_target = 0; res_pred_taken = 0; out_ready = 1; flush = 0; pred_pc = 0;
        @(posedge clk); #1;

        // Reset state
        step(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        step(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 32'h40);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;

        // Condition sweep: a=-1, b=1, prediction not-taken
        sweep_exp = 8'b1001_1010;
        for (int i = 0; i < 8; i++) begin
            step(1, 3'(i), 32'hFFFF_FFFF, 32'h1, 32'h1000 + 32'(i * 4), 32'h2000,
                 0, 1, 0, 32'h0);
            check("sweep_taken", 64'(out_taken), 64'(sweep_exp[i]));
            check("sweep_mp_eq_taken", 64'(out_mispredict), 64'(sweep_exp[i]));
        end
        check("sweep_br_count", 64'(br_count), 64'd6);

        // Predictor training at index 0
        rst_n = 1'b0;
        step(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 32'h40);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            step(1, 3'd0, 32'h5, 32'h5, 32'h40, 32'h80, 0, 1, 0, 32'h40);
        check("train_pred_sat", 64'(pred_taken), 64'd1);
        for (int i = 0; i < 2; i++)
            step(1, 3'd1, 32'h5, 32'h5, 32'h40, 32'h80, 1, 1, 0, 32'h40);
        step(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 32'h40);
        check("train_pred_back_to_wnt", 64'(pred_taken), 64'd0);

        // Backpressure: hold branch B for three cycles, then accept it
        step(1, 3'd0, 32'h1, 32'h1, 32'h80, 32'h300, 0, 1, 0, 32'h80);
        for (int i = 0; i < 3; i++) begin
            step(1, 3'd1, 32'h1, 32'h2, 32'h84, 32'h400, 0, 0, 0, 32'h84);
            check("bp_held_pc", 64'(out_next_pc), 64'h300);
        end
        step(1, 3'd1, 32'h1, 32'h2, 32'h84, 32'h400, 0, 1, 0, 32'h84);
        check("bp_second_pc", 64'(out_next_pc), 64'h400);
        step(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 32'h0);

        // PC wrap and taken target
        step(1, 3'd1, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h100, 0, 1, 0, 32'h0);
        check("wrap_next_pc", 64'(out_next_pc), 64'h0);
        step(1, 3'd0, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h100, 0, 1, 0, 32'h0);
        check("taken_next_pc", 64'(out_next_pc), 64'h100);

        // Counters: 10 conditional (3 mispredicted) plus 2 always-taken
        rst_n = 1'b0;
        step(0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++)
            step(1, 3'd0, 32'h3, 32'h3, 32'(i * 4), 32'h500, (i < 7), 1, 0, 32'h0);
        step(1, 3'd3, 0, 0, 32'h10, 32'h600, 0, 1, 0, 32'h0);
        step(1, 3'd3, 0, 0, 32'h14, 32'h600, 0, 1, 0, 32'h0);
        check("cnt_br_10", 64'(br_count), 64'd10);
        check("cnt_mp_3", 64'(mp_count), 64'd3);
        check("cnt_sat_br_3", 64'(s_br_count), 64'd3);

        // Flush of a held result, and flush alongside an accept
        step(1, 3'd0, 1, 1, 32'h20, 32'h700, 0, 0, 0, 32'h0);
        step(0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
        check("flush_clears", 64'(out_valid), 64'd0);
        step(1, 3'd0, 1, 1, 32'h24, 32'h700, 0, 1, 1, 32'h24);
        check("flush_accept_dropped", 64'(out_valid), 64'd0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rc  = 3'($urandom_range(0, 7));
            rpc = $urandom;
            rpc[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
            step(bit'($urandom_range(0, 3) != 0), rc, ra, rb, rpc, $urandom,
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 0) ? rpc : $urandom);
        end

        // Reset asserted mid-stream with a branch on the input
        step(1, 3'd0, 1, 1, 32'h40, 32'h900, 0, 0, 0, 32'h40);
        rst_n = 1'b0;
        step(1, 3'd0, 1, 1, 32'h40, 32'h900, 0, 0, 0, 32'h40);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_next_pc", 64'(out_next_pc), 64'd0);
        check("midrst_br_count", 64'(br_count), 64'd0);
        rst_n = 1'b1;
        res_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pred_pc = 32'(i * 4);
            #1;
            check("midrst_bht_entry", 64'(pred_taken), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
